csa_tree_pipe: RTL
==================

CSA_TREE_PIPE -- requirements
Module: csa_tree_pipe

Interface
REQ-001 SHALL have parameter N_IN, default 8, number of operands (legal 3..16).
REQ-002 SHALL have parameter W, default 8, operand width in bits (legal 4..16).
REQ-003 SHALL have parameter AVG_SHIFT, default 3, right-shift applied when averaging is compiled in (legal 0..clog2(N_IN)).
REQ-004 SHALL have derived constant OUT_W = W + clog2(N_IN), sum width (11 for defaults).
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port in_data, input, N_IN*W, packed unsigned operands, operand k at bits [k*W +: W].
REQ-008 SHALL have port in_valid, input, 1, in_data is presented.
REQ-009 SHALL have port in_ready, output, 1, block accepts in_data this cycle.
REQ-010 SHALL have port out_data, output, OUT_W, resolved result.
REQ-011 SHALL have port out_valid, output, 1, out_data is valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts out_data.

Function
REQ-013 SHALL reduce N_IN operands with 3:2 carry-save levels (full adders on 3 rows, half adder/pass-through on leftovers), stopping at 2 rows.
REQ-014 SHALL register each CSA level, then add the final 2 rows with a carry-propagate adder in one registered stage.
REQ-015 SHALL have latency LAT = NUM_LEVELS + 1 cycles from input handshake to out_valid (8 operands: 8->6->4->3->2, 4 levels, LAT = 5).
REQ-016 SHALL carry a valid bit per stage, shifted alongside the data.
REQ-017 SHALL advance the whole pipeline when adv = out_ready | ~out_valid; in_ready = adv, combinational.
REQ-018 SHALL capture in_data only when in_valid & in_ready; otherwise stage 0 loads valid = 0.
REQ-019 SHALL hold every stage (data and valid) when adv = 0; out_data stays stable while out_valid & ~out_ready.
REQ-020 SHALL sustain one result per cycle when in_valid and out_ready are held high.
REQ-021 SHALL not drop or duplicate transactions; results leave in acceptance order.
REQ-022 SHALL keep every intermediate row at OUT_W bits (+1 for the rounding term); the sum never overflows OUT_W.
REQ-023 SHALL not compress bubbles; an empty stage ahead of a stalled output does not advance.

Reset
REQ-024 SHALL, on rst high at a clock edge, clear all stage valid bits and data registers, giving out_valid = 0 and out_data = 0 on the following cycle.
REQ-025 SHALL drive in_ready = 1 during and after reset (out_valid = 0 implies adv = 1).
REQ-026 SHALL discard all in-flight transactions when rst is asserted mid-operation; none emerge afterwards.
REQ-027 SHALL give rst priority over a simultaneous input handshake, which is lost.

Configuration
REQ-028 SHALL, with macro CSA_TREE_AVG_ROUND_EN defined, output (sum + 2^(AVG_SHIFT-1)) >> AVG_SHIFT, zero-extended to OUT_W, with the rounding constant injected as an extra CSA row (+0 when AVG_SHIFT = 0).
REQ-029 SHALL, with the macro undefined, output the unshifted sum with no extra row; latency follows REQ-015 for N_IN rows.

Structure
REQ-030 SHALL place in shared package csa_pkg: function csa_levels(n) returning the number of 3:2 levels, clog2 helper, and the OUT_W derivation.
REQ-031 SHALL use one sub-module csa_3to2 (parametrised-width row of full adders returning sum and carry<<1), instantiated per triple per level via generate.

Verification
REQ-032 SHALL check: defaults, all eight operands 255, one input, out_ready = 1 -> out_data = 2040, out_valid exactly 5 cycles after acceptance, macro off.
REQ-033 SHALL check: macro on, AVG_SHIFT = 3, operands {1,1,2,2,1,1,2,2} (sum 12) -> out_data = 2; all 255 -> 255.
REQ-034 SHALL check: 20 back-to-back random vectors with out_ready = 1 -> 20 results on consecutive cycles matching a reference sum, in order.
REQ-035 SHALL check: out_ready low 7 cycles with pipe full -> in_ready = 0, out_data held, no loss; results resume in order after release.
REQ-036 SHALL check: rst pulsed 1 cycle with 3 transactions in flight -> out_valid = 0 next cycle; none of the 3 appears afterwards; in_ready = 1.
REQ-037 SHALL check: N_IN = 3, W = 4, operands 15,15,15 -> out_data = 45 after LAT = 2 cycles.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared helpers for the carry-save tree: level/row counting and result width.
package csa_pkg;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Rows remaining after one 3:2 level: each triple becomes two, leftovers pass.
    function automatic int csa_next(input int r);
        return 2 * (r / 3) + (r % 3);
    endfunction

    function automatic int csa_rows(input int n, input int lvl);
        int r = n;
        for (int i = 0; i < lvl; i++) r = csa_next(r);
        return r;
    endfunction

    function automatic int csa_levels(input int n);
        int r = n;
        int l = 0;
        while (r > 2) begin
            r = csa_next(r);
            l++;
        end
        return l;
    endfunction

    function automatic int csa_out_w(input int n, input int w);
        return w + clog2(n);
    endfunction

endpackage

// File: rtl/csa_3to2.sv
// One row of full adders: three operands in, sum and shifted carry out.
module csa_3to2 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);
    assign sum   = a ^ b ^ c;
    assign carry = ((a & b) | (a & c) | (b & c)) << 1;
endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined carry-save adder tree with a registered final carry-propagate add.
// Define CSA_TREE_AVG_ROUND_EN to output the rounded average (sum >> AVG_SHIFT).
module csa_tree_pipe
    import csa_pkg::*;
#(
    parameter int N_IN      = 8,
    parameter int W         = 8,
    parameter int AVG_SHIFT = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_IN*W-1:0]                in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [csa_out_w(N_IN, W)-1:0]    out_data,
    output logic                             out_valid,
    input  logic                             out_ready
);
    localparam int OUT_W = csa_out_w(N_IN, W);
`ifdef CSA_TREE_AVG_ROUND_EN
    localparam int R0 = N_IN + 1;
    localparam int RW = OUT_W + 1;
`else
    localparam int R0 = N_IN;
    localparam int RW = OUT_W;
`endif
    localparam int NL  = csa_levels(R0);
    localparam int LAT = NL + 1;

    logic              adv;
    logic [LAT:1]      vld_pipe;
    logic [R0-1:0][RW-1:0] rows0;
    logic [RW-1:0]     cpa;
    logic [OUT_W-1:0]  out_nx;

    // Whole pipe moves in lockstep; it only stalls when a valid result is held.
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[LAT];

    for (genvar k = 0; k < N_IN; k++) begin : g_in
        assign rows0[k] = RW'(in_data[k*W +: W]);
    end
`ifdef CSA_TREE_AVG_ROUND_EN
    assign rows0[N_IN] = RW'((2 ** AVG_SHIFT) / 2);
`endif

    always_ff @(posedge clk) begin
        if (rst)
            vld_pipe <= '0;
        else if (adv)
            vld_pipe <= {vld_pipe[LAT-1:1], in_valid & in_ready};
    end

    for (genvar l = 0; l < NL; l++) begin : g_lvl
        localparam int RI = csa_rows(R0, l);
        localparam int RO = csa_rows(R0, l + 1);
        localparam int NT = RI / 3;
        localparam int NP = RI - 3 * NT;

        logic [RI-1:0][RW-1:0] din;
        logic [RO-1:0][RW-1:0] dnx;
        logic [RO-1:0][RW-1:0] dq;

        if (l == 0) begin : g_first
            assign din = rows0;
        end else begin : g_next
            assign din = g_lvl[l-1].dq;
        end

        for (genvar t = 0; t < NT; t++) begin : g_fa
            csa_3to2 #(.W(RW)) u_csa (
                .a     (din[3*t]),
                .b     (din[3*t+1]),
                .c     (din[3*t+2]),
                .sum   (dnx[2*t]),
                .carry (dnx[2*t+1])
            );
        end

        for (genvar j = 0; j < NP; j++) begin : g_pass
            assign dnx[2*NT+j] = din[3*NT+j];
        end

        always_ff @(posedge clk) begin
            if (rst)
                dq <= '0;
            else if (adv)
                dq <= dnx;
        end
    end

    assign cpa = g_lvl[NL-1].dq[0] + g_lvl[NL-1].dq[1];
`ifdef CSA_TREE_AVG_ROUND_EN
    assign out_nx = OUT_W'(cpa >> AVG_SHIFT);
`else
    assign out_nx = cpa;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            out_data <= '0;
        else if (adv)
            out_data <= out_nx;
    end

endmodule
